dpram_rd_stream: RTL and testbench
==================================

// Module: dpram_rd_stream
// PURPOSE
//  Read-side controller for the dual-port frame buffer (port B, 32-bit x 16K words).
//  On a start command it issues sequential port-B reads from start_addr for word_cnt words.
//  It absorbs the RAM read latency in a small output FIFO and presents the words on a
//  valid/ready stream to the downstream consumer. Port A (byte writes) is filled independently.
// PARAMETERS
//  ADDR_W      14  port-B word address width (wraps modulo 2**ADDR_W)
//  DATA_W      32  port-B data width
//  RD_LAT      1   cycles from enb/addrb sampled to doutb valid (1..3)
//  FIFO_DEPTH  4   output FIFO entries, power of 2, >= RD_LAT+2 for 1 word/clk
//  BYTE_SWAP   0   0: m_data=doutb; 1: byte-reversed (byte at addra 4n lands in m_data[31:24])
// PORTS
//  clkb        in   1       single clock, shared with dpram port B
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       start pulse; sampled only while busy=0
//  start_addr  in   ADDR_W  first word address, captured on accepted start
//  word_cnt    in   ADDR_W+1  words to read (0..2**ADDR_W), captured on accepted start
//  abort       in   1       synchronous flush, highest priority
//  busy        out  1       transfer in progress
//  done        out  1       one-cycle pulse, last word handed off
//  enb         out  1       dpram port-B enable (one read per high cycle)
//  addrb       out  ADDR_W  dpram port-B address
//  doutb       in   DATA_W  dpram port-B read data
//  m_data      out  DATA_W  stream data
//  m_valid     out  1       stream valid
//  m_ready     in   1       stream ready; transfer when m_valid & m_ready
// BEHAVIOUR
//  Reset (rst_n=0, async): busy=0, done=0, enb=0, addrb=0, m_valid=0, m_data=0, FIFO empty,
//   in-flight count 0, state IDLE. Reset mid-transfer discards all words.
//  States: IDLE -> READ (start & word_cnt!=0), IDLE -> DONE (start & word_cnt==0),
//   READ -> DRAIN (last read issued), DRAIN -> DONE (last word accepted), DONE -> IDLE.
//  Accepted start at cycle 0: busy=1 from cycle 1; first enb=1, addrb=start_addr in cycle 1.
//  Read issue rule: enb=1 only in READ and when fifo_count + inflight < FIFO_DEPTH; addrb
//   increments by 1 after each issued read, 2**ADDR_W-1 wraps to 0. enb=0 otherwise.
//  doutb is written into the FIFO exactly RD_LAT cycles after its enb cycle; the FIFO never
//   overflows by the issue rule. inflight = issued reads not yet written into the FIFO.
//  m_valid = FIFO not empty; first m_valid in cycle 2+RD_LAT after start when m_ready held.
//   m_data/m_valid hold stable while m_valid & !m_ready. Simultaneous push and pop legal.
//  Words leave in address order; total handed off = word_cnt exactly.
//  done: 1 cycle, the cycle after the last m_valid&m_ready (DONE state); busy falls with
//   done's falling edge. word_cnt=0: no enb, no m_valid, done in cycle 1, busy only in cycle 1.
//  start while busy=1 is ignored (no capture, no effect).
//  abort=1 (any state): next cycle enb=0, m_valid=0, FIFO flushed, in-flight returns dropped
//   (not pushed), busy=0, state IDLE, no done pulse. abort & start same cycle: abort wins.
//  Throughput: 1 word/clk sustained with m_ready=1 and FIFO_DEPTH >= RD_LAT+2.
// TESTING
//  T1 port A bytes 1..8 at addra 0..7; start_addr=0, word_cnt=2, m_ready=1 -> m_data
//     32'h04030201 then 32'h08070605, first m_valid 3 cycles after start, done 1 cycle later.
//  T2 word_cnt=16, m_ready=1 -> enb high 16 consecutive cycles, 16 back-to-back words, no gaps.
//  T3 word_cnt=10, m_ready toggled 1/0 pseudo-randomly -> order intact, no drop or duplicate,
//     enb never raised when fifo_count+inflight=4, data stable while stalled.
//  T4 start_addr=16382, word_cnt=4 -> addrb 16382,16383,0,1; data from those words in order.
//  T5 word_cnt=0 -> no enb, no m_valid, done in cycle 1; start during busy -> ignored.
//  T6 abort at 5th accepted word of 12 with m_ready=0 -> next cycle m_valid=0, busy=0, no done;
//     new start_addr=0, word_cnt=1 -> single word 32'h04030201. Repeat with rst_n pulse: same.

Source files
------------

// File: rtl/dpram_rd_stream_if.sv
// rtl/dpram_rd_stream_if.sv - valid/ready word stream from the frame-buffer read controller
interface dpram_rd_stream_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/dpram_rd_stream.sv
// rtl/dpram_rd_stream.sv - port-B sequential reader with latency-absorbing output FIFO
module dpram_rd_stream #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int BYTE_SWAP  = 0
) (
  input  logic              clkb,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  dpram_rd_stream_if.master m
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // wide enough for fifo_count + inflight without overflow
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   WORD_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rd_left_q, rd_left_d;
  logic [ADDR_W:0]   out_left_q, out_left_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;

  logic [CNT_W-1:0]  inflight;
  logic [DATA_W-1:0] data_in;
  logic              fifo_valid;
  logic              push;
  logic              pop;
  logic              room;

  assign fifo_valid = (fifo_count_q != '0);
  assign push       = pipe_q[RD_LAT-1];
  assign pop        = fifo_valid & m.m_ready;
  assign m.m_valid  = fifo_valid;
  assign m.m_data   = fifo_valid ? mem_q[rd_ptr_q] : '0;
  assign addrb      = addr_q;

  // Count reads still travelling through the RAM pipeline and apply optional byte reversal.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i]);
    end
    data_in = doutb;
    if (BYTE_SWAP != 0) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        data_in[8*b +: 8] = doutb[DATA_W-8-8*b +: 8];
      end
    end
  end

  // Transfer FSM: captures the command, issues reads while FIFO space is reserved, tracks hand-offs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_left_d  = rd_left_q;
    out_left_d = out_left_q;
    enb        = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    // every issued read owns a FIFO slot until it is popped, so overflow is impossible
    room       = ((fifo_count_q + inflight) < DEPTH_C);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = start_addr;
          rd_left_d  = word_cnt;
          out_left_d = word_cnt;
          state_d    = (word_cnt == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        enb = room;
        if (room) begin
          addr_d    = addr_q + ADDR_ONE;
          rd_left_d = rd_left_q - WORD_ONE;
          if (rd_left_q == WORD_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DRAIN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      out_left_d = out_left_q - WORD_ONE;
      if (out_left_q == WORD_ONE) begin
        state_d = S_DONE;
      end
    end

    if (abort) begin
      state_d    = S_IDLE;
      rd_left_d  = '0;
      out_left_d = '0;
    end
  end

  // Read-latency pipeline and output FIFO; abort drops both the stored and the returning words.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = enb;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_ONE;
      2'b01:   fifo_count_d = fifo_count_q - CNT_ONE;
      default: fifo_count_d = fifo_count_q;
    endcase

    if (abort) begin
      pipe_d       = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end
  end

  // State register for the FSM, address/count trackers, pipeline and FIFO storage.
  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rd_left_q    <= '0;
      out_left_q   <= '0;
      pipe_q       <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_left_q    <= rd_left_d;
      out_left_q   <= out_left_d;
      pipe_q       <= pipe_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

endmodule

// File: tb/tb_dpram_rd_stream.sv
// tb/tb_dpram_rd_stream.sv - self-checking bench for the port-B read stream controller
module tb_dpram_rd_stream;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int WORDS  = 16384;

  logic              clkb = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_cnt;
  logic              abort;
  logic              busy;
  logic              done;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] doutb;

  dpram_rd_stream_if #(.DATA_W(DATA_W)) s_if ();

  dpram_rd_stream #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .FIFO_DEPTH(4), .BYTE_SWAP(0)
  ) dut (
    .clkb(clkb), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .word_cnt(word_cnt), .abort(abort), .busy(busy), .done(done), .enb(enb),
    .addrb(addrb), .doutb(doutb), .m(s_if)
  );

  always #5 clkb = ~clkb;

  // frame buffer model: port B with one cycle read latency
  logic [31:0] ram [WORDS];
  always @(posedge clkb) if (enb) doutb <= ram[addrb];

  int checks = 0;
  int passes = 0;
  int occ = 0;
  int done_cnt = 0;
  logic [31:0]       exp_data [$];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [31:0]       got [$];
  logic              prev_stall = 1'b0;
  logic              prev_flush = 1'b1;
  logic [31:0]       prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // stream/port-B monitor against the scoreboard queues
  always @(negedge clkb) begin
    if (rst_n) begin
      if (enb) begin
        chk("occ_room", 64'(occ < 4), 64'd1);
        chk("enb_expected", 64'(exp_addr.size() != 0), 64'd1);
        if (exp_addr.size() != 0) chk("addrb", 64'(addrb), 64'(exp_addr.pop_front()));
        occ++;
      end
      if (prev_stall && !prev_flush) begin
        chk("stall_valid", 64'(s_if.m_valid), 64'd1);
        chk("stall_data", 64'(s_if.m_data), 64'(prev_data));
      end
      if (s_if.m_valid && s_if.m_ready) begin
        got.push_back(s_if.m_data);
        chk("word_expected", 64'(exp_data.size() != 0), 64'd1);
        if (exp_data.size() != 0) chk("m_data", 64'(s_if.m_data), 64'(exp_data.pop_front()));
        occ--;
      end
      if (done) done_cnt++;
    end
    prev_stall = rst_n && s_if.m_valid && !s_if.m_ready;
    prev_data  = s_if.m_data;
    prev_flush = abort || !rst_n;
  end

  task automatic cyc();
    @(posedge clkb);
    #2;
  endtask

  task automatic write_byte(input int a, input logic [7:0] d);
    ram[a / 4][8*(a % 4) +: 8] = d;
  endtask

  task automatic do_start(input int a, input int n);
    start      = 1'b1;
    start_addr = ADDR_W'(a);
    word_cnt   = (ADDR_W+1)'(n);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(ADDR_W'(a + i));
      exp_data.push_back(ram[(a + i) % WORDS]);
    end
    cyc();
    start = 1'b0;
  endtask

  task automatic flush_model();
    exp_addr.delete();
    exp_data.delete();
    occ = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < 400) begin
      cyc();
      k++;
    end
    chk({tag, "_done_once"}, 64'(done_cnt - n0), 64'd1);
    cyc();
    @(negedge clkb);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_all_words"}, 64'(exp_data.size()), 64'd0);
    cyc();
  endtask

  // cycle-exact profile for an unstalled transfer of n words started in cycle 0
  task automatic timed(input string tag, input int n);
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clkb);
      chk($sformatf("%s_enb_c%0d", tag, c), 64'(enb), 64'(c <= n));
      chk($sformatf("%s_valid_c%0d", tag, c), 64'(s_if.m_valid), 64'(c >= 3 && c <= n + 2));
      chk($sformatf("%s_done_c%0d", tag, c), 64'(done), 64'(c == n + 3));
      chk($sformatf("%s_busy_c%0d", tag, c), 64'(busy), 64'(c <= n + 3));
    end
    cyc();
    chk({tag, "_all_words"}, 64'(exp_data.size()), 64'd0);
  endtask

  task automatic abort_or_reset_case(input string tag, input bit use_reset);
    int d0;
    int k;
    got.delete();
    s_if.m_ready = 1'b1;
    do_start(0, 12);
    k = 0;
    while (got.size() < 5 && k < 100) begin
      cyc();
      k++;
    end
    chk({tag, "_five_taken"}, 64'(got.size()), 64'd5);
    d0 = done_cnt;
    s_if.m_ready = 1'b0;
    if (use_reset) begin
      rst_n = 1'b0;
      flush_model();
      @(negedge clkb);
      chk({tag, "_rst_addrb"}, 64'(addrb), 64'd0);
      chk({tag, "_rst_mdata"}, 64'(s_if.m_data), 64'd0);
      cyc();
      rst_n = 1'b1;
    end else begin
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      flush_model();
    end
    @(negedge clkb);
    chk({tag, "_valid_low"}, 64'(s_if.m_valid), 64'd0);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_enb_low"}, 64'(enb), 64'd0);
    for (int i = 0; i < 4; i++) cyc();
    chk({tag, "_no_done"}, 64'(done_cnt), 64'(d0));
    chk({tag, "_no_more_words"}, 64'(got.size()), 64'd5);
    got.delete();
    s_if.m_ready = 1'b1;
    do_start(0, 1);
    wait_idle({tag, "_restart"});
    chk({tag, "_single_count"}, 64'(got.size()), 64'd1);
    chk({tag, "_single_word"}, 64'(got.size() > 0 ? got[0] : 32'h0), 64'h04030201);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start_addr = '0;
    word_cnt = '0;
    s_if.m_ready = 1'b0;
    for (int i = 0; i < WORDS; i++) ram[i] = 32'h5A000000 ^ 32'(i * 32'h00010003);
    for (int a = 0; a < 8; a++) write_byte(a, 8'(a + 1));

    // reset state
    @(negedge clkb);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_enb", 64'(enb), 64'd0);
    chk("rst_addrb", 64'(addrb), 64'd0);
    chk("rst_valid", 64'(s_if.m_valid), 64'd0);
    chk("rst_data", 64'(s_if.m_data), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // T1: two words from the bytes written through port A
    s_if.m_ready = 1'b1;
    got.delete();
    do_start(0, 2);
    timed("t1", 2);
    chk("t1_count", 64'(got.size()), 64'd2);
    chk("t1_word0", 64'(got.size() > 0 ? got[0] : 32'h0), 64'h04030201);
    chk("t1_word1", 64'(got.size() > 1 ? got[1] : 32'h0), 64'h08070605);

    // T2: sixteen words back to back
    do_start(32, 16);
    timed("t2", 16);

    // T3: random backpressure
    got.delete();
    do_start(100, 10);
    begin
      int n0;
      int k;
      n0 = done_cnt;
      k = 0;
      while (done_cnt == n0 && k < 400) begin
        s_if.m_ready = 1'($urandom_range(0, 1));
        cyc();
        k++;
      end
      chk("t3_done_once", 64'(done_cnt - n0), 64'd1);
    end
    s_if.m_ready = 1'b1;
    cyc();
    chk("t3_count", 64'(got.size()), 64'd10);
    chk("t3_all_words", 64'(exp_data.size()), 64'd0);

    // T4: address wrap at the top of port B
    got.delete();
    do_start(16382, 4);
    wait_idle("t4");
    chk("t4_count", 64'(got.size()), 64'd4);
    chk("t4_addrs", 64'(exp_addr.size()), 64'd0);

    // T5: zero-length transfer, and a start while busy
    got.delete();
    do_start(7, 0);
    start = 1'b1;
    start_addr = ADDR_W'(5);
    word_cnt = (ADDR_W+1)'(3);
    @(negedge clkb);
    chk("t5_done_c1", 64'(done), 64'd1);
    chk("t5_busy_c1", 64'(busy), 64'd1);
    chk("t5_enb_c1", 64'(enb), 64'd0);
    chk("t5_valid_c1", 64'(s_if.m_valid), 64'd0);
    cyc();
    start = 1'b0;
    @(negedge clkb);
    chk("t5_busy_c2", 64'(busy), 64'd0);
    chk("t5_done_c2", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) cyc();
    chk("t5_zero_words", 64'(got.size()), 64'd0);
    do_start(200, 3);
    start = 1'b1;
    start_addr = '0;
    word_cnt = (ADDR_W+1)'(5);
    cyc();
    start = 1'b0;
    wait_idle("t5b");
    chk("t5b_count", 64'(got.size()), 64'd3);

    // T6: abort mid-transfer, then the same with a reset pulse
    abort_or_reset_case("t6a", 1'b0);
    abort_or_reset_case("t6r", 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
